// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, FSM encoding and legality helper
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SLT = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_NOT,
      OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_SLT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// rtl/alu_share_ctrl_alu.sv - combinational 8-bit ALU datapath
module alu_share_ctrl_alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] y
);

  // Carry/borrow out of ADD/SUB is dropped by the 8-bit result; SLT compares signed.
  always_comb begin
    y = 8'h00;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = {4'h0, a[3:0]} * {4'h0, b[3:0]};
      OP_OR:  y = a | b;
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_XOR: y = a ^ b;
      OP_SLL: y = a << b[2:0];
      OP_SRL: y = a >> b[2:0];
      OP_SLT: y = {7'd0, ($signed(a) < $signed(b))};
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-requester round-robin front end for the shared ALU
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [7:0]       req_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_t      state, state_nx;
  logic        prio;
  logic        gnt_q;
  logic        win;
  logic        hs;
  logic        rsp_fire;
  logic [7:0]  a_q, b_q;
  logic [3:0]  op_q;
  logic [7:0]  alu_y;

  alu_share_ctrl_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // A lone requester wins outright; prio only breaks ties.
  assign win = (req_valid == 2'b11) ? prio : req_valid[1];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    hs        = 1'b0;
    rsp_fire  = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = win ? 2'b10 : 2'b01;
          hs        = 1'b1;
          state_nx  = ST_EXEC;
        end
      end
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          rsp_fire = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= 1'b0;
      gnt_q      <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 4'h0;
      rsp_result <= 8'h00;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (hs) begin
        gnt_q <= win;
        a_q   <= win ? req_a[15:8] : req_a[7:0];
        b_q   <= win ? req_b[15:8] : req_b[7:0];
        op_q  <= win ? req_op[7:4] : req_op[3:0];
      end
      if (state == ST_EXEC) begin
        if (op_legal(op_q)) begin
          rsp_result <= alu_y;
          rsp_err    <= 1'b0;
        end else begin
          rsp_result <= 8'h00;
          rsp_err    <= 1'b1;
        end
      end
      // Completion hands priority to the other requester, so a waiting loser goes next.
      if (rsp_fire) begin
        prio <= ~gnt_q;
        if (ops_done != '1) ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
